// File: rtl/uart_cmd_rx_pkg.sv
// Shared definitions for the host-to-FPGA command receiver.
// Contents:
//   HDR_DEFAULT / TAIL_DEFAULT  frame delimiter bytes
//   parser_state_t              frame parser states
//   bit_state_t                 UART bit-level receiver states
//   baud_div()                  clock cycles per bit for a given clock and line rate
package uart_cmd_rx_pkg;

    localparam logic [7:0] HDR_DEFAULT  = 8'hAA;
    localparam logic [7:0] TAIL_DEFAULT = 8'h55;

    typedef enum logic [2:0] {
        WAIT_HDR,
        GET_CMD,
        GET_DATA,
        GET_SUM,
        GET_TAIL
    } parser_state_t;

    typedef enum logic [1:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_STOP
    } bit_state_t;

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Command receiver bus: serial line in, validated command out.
// Signals:
//   uart_rx    serial input, idle high
//   cmd_valid  one-cycle pulse, good frame received
//   cmd_code   CMD byte of last good frame
//   cmd_data   {D3,D2,D1,D0} of last good frame
//   frame_err  one-cycle pulse, framing/checksum/tail/timeout error
//   rx_busy    receiver is mid-frame or mid-byte
// Modports: master = the receiver, slave = the consumer / line driver.
interface uart_cmd_rx_if;
    logic        uart_rx;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [31:0] cmd_data;
    logic        frame_err;
    logic        rx_busy;

    modport master (
        input  uart_rx,
        output cmd_valid, cmd_code, cmd_data, frame_err, rx_busy
    );

    modport slave (
        output uart_rx,
        input  cmd_valid, cmd_code, cmd_data, frame_err, rx_busy
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, baud counter and bit FSM.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   rx_in        asynchronous serial input, idle high
//   byte_vld     one-cycle strobe, byte received with a good stop bit
//   byte_data    received byte, stable from byte_vld until the next byte's data bits
//   stop_err     one-cycle strobe, stop bit sampled low (byte discarded)
//   busy         a byte is being received
module uart_rx_byte #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       stop_err,
    output logic       busy
);
    import uart_cmd_rx_pkg::*;

    localparam int               CNT_W   = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);

    logic [1:0]       sync_q, sync_d;
    logic             prev_q, prev_d;
    bit_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_vld_q, byte_vld_d;
    logic             stop_err_q, stop_err_d;
    logic             rx_s;

    assign rx_s = sync_q[1];

    // Start is an edge, not a level, so a line held low after a bad stop
    // bit does not retrigger. The start bit is re-checked at half a bit to
    // reject glitches; after that every sample lands on a bit centre.
    always_comb begin
        sync_d     = {sync_q[0], rx_in};
        prev_d     = rx_s;
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_vld_d = 1'b0;
        stop_err_d = 1'b0;
        case (state_q)
            BIT_IDLE: begin
                if (prev_q && !rx_s) begin
                    state_d = BIT_START;
                    cnt_d   = '0;
                end
            end
            BIT_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? BIT_IDLE : BIT_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BIT_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = BIT_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BIT_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d      = '0;
                    state_d    = BIT_IDLE;
                    byte_vld_d = rx_s;
                    stop_err_d = !rx_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = BIT_IDLE;
        endcase
    end

    // Synchroniser and edge history preset to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            prev_q     <= 1'b1;
            state_q    <= BIT_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            byte_vld_q <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            byte_vld_q <= byte_vld_d;
            stop_err_q <= stop_err_d;
        end
    end

    assign byte_vld  = byte_vld_q;
    assign byte_data = shift_q;
    assign stop_err  = stop_err_q;
    assign busy      = (state_q != BIT_IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// Host command receiver: parses 8-byte frames AA CMD D3 D2 D1 D0 SUM 55
// arriving over 8N1 UART and delivers the command and 32-bit operand.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          uart_cmd_rx_if.master: uart_rx in; cmd_valid, cmd_code,
//                cmd_data, frame_err, rx_busy out
module uart_cmd_rx #(
    parameter int         CLK_FREQ    = 50_000_000,
    parameter int         BAUD        = 115200,
    parameter logic [7:0] HDR         = uart_cmd_rx_pkg::HDR_DEFAULT,
    parameter logic [7:0] TAIL        = uart_cmd_rx_pkg::TAIL_DEFAULT,
    parameter int         TIMEOUT_BIT = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_cmd_rx_if.master    bus
);
    import uart_cmd_rx_pkg::*;

    localparam int            BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int            TO_LIMIT = TIMEOUT_BIT * BAUD_DIV;
    localparam int            TO_W     = $clog2(TO_LIMIT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

    logic       byte_vld;
    logic [7:0] byte_data;
    logic       stop_err;
    logic       byte_busy;

    uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_byte (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_in    (bus.uart_rx),
        .byte_vld (byte_vld),
        .byte_data(byte_data),
        .stop_err (stop_err),
        .busy     (byte_busy)
    );

    parser_state_t state_q, state_d;
    logic [7:0]    cmd_lat_q, cmd_lat_d;
    logic [31:0]   data_sh_q, data_sh_d;
    logic [7:0]    sum_q, sum_d;
    logic          sum_bad_q, sum_bad_d;
    logic [1:0]    idx_q, idx_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    cmd_code_q, cmd_code_d;
    logic [31:0]   cmd_data_q, cmd_data_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          frame_err_q, frame_err_d;

    // The command is staged in cmd_lat/data_sh and only copied to the
    // outputs once the tail confirms the frame, so outputs never show a
    // partial update. A checksum mismatch is remembered and judged at the
    // tail so a bad frame still consumes all eight bytes. The idle timer
    // restarts on every strobe and while a byte is arriving.
    always_comb begin
        state_d     = state_q;
        cmd_lat_d   = cmd_lat_q;
        data_sh_d   = data_sh_q;
        sum_d       = sum_q;
        sum_bad_d   = sum_bad_q;
        idx_d       = idx_q;
        to_cnt_d    = to_cnt_q;
        cmd_code_d  = cmd_code_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        if (stop_err) begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HDR;
            to_cnt_d    = '0;
        end else if (byte_vld) begin
            to_cnt_d = '0;
            case (state_q)
                WAIT_HDR: begin
                    if (byte_data == HDR) state_d = GET_CMD;
                end
                GET_CMD: begin
                    cmd_lat_d = byte_data;
                    sum_d     = byte_data;
                    idx_d     = 2'd3;
                    state_d   = GET_DATA;
                end
                GET_DATA: begin
                    data_sh_d = {data_sh_q[23:0], byte_data};
                    sum_d     = sum_q + byte_data;
                    idx_d     = idx_q - 2'd1;
                    if (idx_q == 2'd0) state_d = GET_SUM;
                end
                GET_SUM: begin
                    sum_bad_d = (byte_data != sum_q);
                    state_d   = GET_TAIL;
                end
                GET_TAIL: begin
                    if (byte_data == TAIL && !sum_bad_q) begin
                        cmd_valid_d = 1'b1;
                        cmd_code_d  = cmd_lat_q;
                        cmd_data_d  = data_sh_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = WAIT_HDR;
                end
                default: state_d = WAIT_HDR;
            endcase
        end else if (state_q == WAIT_HDR || byte_busy) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HDR;
            to_cnt_d    = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_HDR;
            cmd_lat_q   <= '0;
            data_sh_q   <= '0;
            sum_q       <= '0;
            sum_bad_q   <= 1'b0;
            idx_q       <= '0;
            to_cnt_q    <= '0;
            cmd_code_q  <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_lat_q   <= cmd_lat_d;
            data_sh_q   <= data_sh_d;
            sum_q       <= sum_d;
            sum_bad_q   <= sum_bad_d;
            idx_q       <= idx_d;
            to_cnt_q    <= to_cnt_d;
            cmd_code_q  <= cmd_code_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_code  = cmd_code_q;
    assign bus.cmd_data  = cmd_data_q;
    assign bus.frame_err = frame_err_q;
    assign bus.rx_busy   = (state_q != WAIT_HDR) || byte_busy;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Testbench for uart_cmd_rx: directed frame vectors, glitch, timeout and
// mid-frame reset sequences, then random frames checked against a
// frame-level reference model.
module tb_uart_cmd_rx;

    // Reduced clock so a bit lasts 40 clk and the run stays short.
    localparam int         CLK_FREQ    = 4_608_000;
    localparam int         BAUD        = 115200;
    localparam int         BIT_CLKS    = CLK_FREQ / BAUD;
    localparam int         TIMEOUT_BIT = 20;
    localparam logic [7:0] HDR         = 8'hAA;
    localparam logic [7:0] TAIL        = 8'h55;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        bit          is_err;
        logic [7:0]  code;
        logic [31:0] data;
    } event_t;
    typedef event_t event_q_t[$];

    typedef struct {
        string       name;
        logic [95:0] bytes;
        int          n;
        int          bad_idx;
        int          exp_valid;
        int          exp_err;
        logic [7:0]  exp_code;
        logic [31:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt = 0;
    int   both_cnt = 0;
    event_q_t act_q;

    always #5 clk = ~clk;

    uart_cmd_rx_if bus ();

    uart_cmd_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .HDR        (HDR),
        .TAIL       (TAIL),
        .TIMEOUT_BIT(TIMEOUT_BIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Record every output pulse with the output values seen alongside it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cmd_valid || bus.frame_err) pulse_cnt++;
            if (bus.cmd_valid && bus.frame_err) both_cnt++;
            if (bus.cmd_valid)
                act_q.push_back('{1'b0, bus.cmd_code, bus.cmd_data});
            else if (bus.frame_err)
                act_q.push_back('{1'b1, bus.cmd_code, bus.cmd_data});
        end
    end

    // Hard stop in case something stalls the sequences below.
    initial begin
        repeat (400_000) @(posedge clk);
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 400000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input bit stop_ok);
        bus.uart_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        bus.uart_rx = stop_ok;
        repeat (BIT_CLKS) @(negedge clk);
        bus.uart_rx = 1'b1;
        if (!stop_ok) repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic applyStimulus(input byte_q_t seq, input int bad_idx, input int max_gap);
        foreach (seq[i]) begin
            sendByte(seq[i], i != bad_idx);
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    function automatic byte_q_t toQueue(input logic [95:0] p, input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(p[8*(n-1-i) +: 8]);
        return q;
    endfunction

    function automatic int countKind(input event_q_t q, input bit is_err);
        int c = 0;
        foreach (q[i]) if (q[i].is_err == is_err) c++;
        return c;
    endfunction

    // Frame-level reference: scan for a header, take the next eight bytes
    // as a whole frame, and judge it by its checksum and tail.
    function automatic void refModel(input byte_q_t s, input logic [7:0] code_in,
                                     input logic [31:0] data_in, output event_q_t exp,
                                     output logic [7:0] code_out, output logic [31:0] data_out);
        int i = 0;
        int total;
        exp = {};
        code_out = code_in;
        data_out = data_in;
        while (i < s.size()) begin
            if (s[i] != HDR) begin
                i++;
            end else if (i + 8 > s.size()) begin
                break;
            end else begin
                total = 0;
                for (int k = 1; k <= 5; k++) total += int'(s[i+k]);
                if (int'(s[i+6]) == total % 256 && s[i+7] == TAIL) begin
                    code_out = s[i+1];
                    data_out = {s[i+2], s[i+3], s[i+4], s[i+5]};
                    exp.push_back('{1'b0, code_out, data_out});
                end else begin
                    exp.push_back('{1'b1, code_out, data_out});
                end
                i += 8;
            end
        end
    endfunction

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_cmd_valid"}, 32'(bus.cmd_valid), 32'd0);
        checkOutput({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
        checkOutput({tag, "_cmd_code"}, 32'(bus.cmd_code), 32'd0);
        checkOutput({tag, "_cmd_data"}, bus.cmd_data, 32'd0);
        checkOutput({tag, "_rx_busy"}, 32'(bus.rx_busy), 32'd0);
    endtask

    task automatic checkCounts(input string tag, input int valid, input int err,
                               input logic [7:0] code, input logic [31:0] data);
        checkOutput({tag, "_valid_cnt"}, countKind(act_q, 1'b0), valid);
        checkOutput({tag, "_err_cnt"}, countKind(act_q, 1'b1), err);
        checkOutput({tag, "_cmd_code"}, 32'(bus.cmd_code), 32'(code));
        checkOutput({tag, "_cmd_data"}, bus.cmd_data, data);
    endtask

    initial begin
        vec_t        vecs[4];
        byte_q_t     seq;
        event_q_t    exp_q;
        logic [7:0]  m_code, m_code_n;
        logic [31:0] m_data, m_data_n;
        logic [7:0]  f[8];
        int          total;
        bit          seen;

        vecs[0] = '{"good", 96'({8'hAA, 8'h01, 8'h00, 8'h00, 8'hC3, 8'h50, 8'h14, 8'h55}),
                    8, -1, 1, 0, 8'h01, 32'h0000C350};
        vecs[1] = '{"bad_sum", 96'({8'hAA, 8'h01, 8'h00, 8'h00, 8'hC3, 8'h50, 8'h15, 8'h55}),
                    8, -1, 0, 1, 8'h01, 32'h0000C350};
        vecs[2] = '{"garbage", 96'({8'h12, 8'h34, 8'hAA, 8'h02, 8'h00, 8'h00, 8'h00, 8'h0A,
                    8'h0C, 8'h55}), 10, -1, 1, 0, 8'h02, 32'h0000000A};
        vecs[3] = '{"stop_err", {8'hAA, 8'h03, 8'h11, 8'h22, 8'hAA, 8'h03, 8'h11, 8'h22,
                    8'h33, 8'h44, 8'hAD, 8'h55}, 12, 3, 1, 1, 8'h03, 32'h11223344};

        bus.uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkIdle("reset");

        for (int v = 0; v < 4; v++) begin
            act_q.delete();
            applyStimulus(toQueue(vecs[v].bytes, vecs[v].n), vecs[v].bad_idx, 0);
            repeat (2 * BIT_CLKS) @(negedge clk);
            checkCounts(vecs[v].name, vecs[v].exp_valid, vecs[v].exp_err,
                        vecs[v].exp_code, vecs[v].exp_data);
        end

        // A short low pulse between CMD and D3 must not be taken as a byte.
        act_q.delete();
        applyStimulus('{8'hAA, 8'h05}, -1, 0);
        bus.uart_rx = 1'b0;
        repeat (BIT_CLKS / 3) @(negedge clk);
        bus.uart_rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        applyStimulus('{8'h01, 8'h02, 8'h03, 8'h04, 8'h0F, 8'h55}, -1, 0);
        repeat (2 * BIT_CLKS) @(negedge clk);
        checkCounts("glitch", 1, 0, 8'h05, 32'h01020304);
        checkOutput("glitch_rx_busy", 32'(bus.rx_busy), 32'd0);

        // Frame abandoned after D2: error after the idle limit, not before.
        act_q.delete();
        applyStimulus('{8'hAA, 8'h06, 8'h11, 8'h22}, -1, 0);
        repeat ((TIMEOUT_BIT - 2) * BIT_CLKS) @(negedge clk);
        checkOutput("timeout_early", act_q.size(), 32'd0);
        checkOutput("timeout_busy_before", 32'(bus.rx_busy), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 4 * BIT_CLKS && !seen; k++) begin
            @(negedge clk);
            seen = bus.frame_err;
        end
        checkOutput("timeout_seen", 32'(seen), 32'd1);
        repeat (4) @(negedge clk);
        checkCounts("timeout", 0, 1, 8'h05, 32'h01020304);
        checkOutput("timeout_rx_busy", 32'(bus.rx_busy), 32'd0);

        // Reset while D1 is on the line, then a clean frame.
        applyStimulus('{8'hAA, 8'h07, 8'h01, 8'h02}, -1, 0);
        bus.uart_rx = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        bus.uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkIdle("mid_reset");
        act_q.delete();
        applyStimulus('{8'hAA, 8'h08, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h40, 8'h55}, -1, 0);
        repeat (2 * BIT_CLKS) @(negedge clk);
        checkCounts("after_reset", 1, 0, 8'h08, 32'hDEADBEEF);

        // Random frames, some corrupted, wrapped in non-header junk.
        m_code = 8'h08;
        m_data = 32'hDEADBEEF;
        for (int it = 0; it < 6; it++) begin
            seq = {};
            repeat ($urandom_range(0, 2)) begin
                logic [7:0] g = 8'($urandom_range(0, 255));
                seq.push_back(g == HDR ? 8'h00 : g);
            end
            f[0] = HDR;
            for (int k = 1; k <= 5; k++) f[k] = 8'($urandom_range(0, 255));
            if (it == 0) f[2] = HDR;
            total = 0;
            for (int k = 1; k <= 5; k++) total += int'(f[k]);
            f[6] = 8'(total % 256);
            f[7] = TAIL;
            case ($urandom_range(0, 2))
                1: f[6] = f[6] + 8'(1 + $urandom_range(0, 254));
                2: f[7] = TAIL ^ 8'(1 + $urandom_range(0, 254));
                default: ;
            endcase
            for (int k = 0; k < 8; k++) seq.push_back(f[k]);
            if ($urandom_range(0, 1) == 1) seq.push_back(8'h5A);
            refModel(seq, m_code, m_data, exp_q, m_code_n, m_data_n);
            m_code = m_code_n;
            m_data = m_data_n;
            act_q.delete();
            applyStimulus(seq, -1, 20);
            repeat (2 * BIT_CLKS) @(negedge clk);
            checkOutput($sformatf("rnd%0d_events", it), act_q.size(), exp_q.size());
            for (int e = 0; e < exp_q.size() && e < act_q.size(); e++) begin
                checkOutput($sformatf("rnd%0d_kind%0d", it, e), 32'(act_q[e].is_err),
                            32'(exp_q[e].is_err));
                checkOutput($sformatf("rnd%0d_code%0d", it, e), 32'(act_q[e].code),
                            32'(exp_q[e].code));
                checkOutput($sformatf("rnd%0d_data%0d", it, e), act_q[e].data, exp_q[e].data);
            end
        end

        checkOutput("pulses_seen", 32'(pulse_cnt > 0), 32'd1);
        checkOutput("valid_err_overlap", both_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
